// File: rtl/iob_skid_buf.sv
// Two-entry valid/ready skid buffer: registered forward data/valid and registered backward ready.
// Clock enable and synchronous reset behave like iob_reg_r; arst_i clears the buffer immediately.
module iob_skid_buf #(
  parameter int unsigned DATA_W  = 21,
  parameter int          RST_VAL = 0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i
);

  localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(RST_VAL);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              rdy_q;
  logic              main_v;
  logic              s_fire;
  logic              m_fire;

  // Valid flags are decoded from the state; rdy_q is kept as its own register
  // so s_ready_o never depends combinationally on m_ready_i or s_valid_i.
  assign main_v    = (state_q != EMPTY);
  assign s_ready_o = rdy_q  & cke_i & ~rst_i;
  assign m_valid_o = main_v & cke_i & ~rst_i;
  assign m_data_o  = main_q;
  assign s_fire    = s_valid_i & s_ready_o;
  assign m_fire    = m_valid_o & m_ready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
      rdy_q   <= 1'b1;
    end else if (cke_i) begin
      if (rst_i) begin
        state_q <= EMPTY;
        main_q  <= RST_DATA;
        skid_q  <= RST_DATA;
        rdy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (s_fire) begin
              state_q <= BUSY;
              main_q  <= s_data_i;
            end
          end
          BUSY: begin
            if (s_fire && m_fire) begin
              main_q <= s_data_i;
            end else if (s_fire) begin
              state_q <= FULL;
              skid_q  <= s_data_i;
              rdy_q   <= 1'b0;
            end else if (m_fire) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (m_fire) begin
              state_q <= BUSY;
              main_q  <= skid_q;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_skid_buf.sv
// Scoreboard bench for iob_skid_buf: a word-queue reference model predicts handshakes,
// a separate monitor pops expected words whenever the DUT transfers downstream.
module tb_iob_skid_buf;

  localparam int unsigned W  = 21;
  localparam int          RV = 'h15A5A;
  localparam logic [W-1:0] RSTV = W'(RV);

  logic         clk     = 1'b0;
  logic         arst    = 1'b1;
  logic         cke     = 1'b1;
  logic         rst     = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data  = '0;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready = 1'b0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [W-1:0] mdl[$];  // words held by the buffer (head = word on the output)
  logic [W-1:0] sb[$];   // words accepted but not yet delivered
  logic [W-1:0] last_out = RSTV;

  iob_skid_buf #(
    .DATA_W (W),
    .RST_VAL(RV)
  ) dut (
    .clk_i    (clk),
    .arst_i   (arst),
    .cke_i    (cke),
    .rst_i    (rst),
    .s_valid_i(s_valid),
    .s_data_i (s_data),
    .s_ready_o(s_ready),
    .m_valid_o(m_valid),
    .m_data_o (m_data),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic step(input logic sv, input logic [W-1:0] d, input logic mr,
                      input logic ce, input logic rs);
    logic en;
    logic mf;
    logic sf;
    @(negedge clk);
    #1;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    cke     = ce;
    rst     = rs;
    #1;
    en = ce & ~rs;
    check("s_ready", W'(s_ready), W'(en && (mdl.size() < 2)));
    check("m_valid", W'(m_valid), W'(en && (mdl.size() > 0)));
    check("m_data", m_data, (mdl.size() > 0) ? mdl[0] : last_out);
    if (ce) begin
      if (rs) begin
        mdl.delete();
        sb.delete();
        last_out = RSTV;
      end else begin
        mf = (mdl.size() > 0) && mr;
        sf = (mdl.size() < 2) && sv;
        if (mf) last_out = mdl.pop_front();
        if (sf) begin
          mdl.push_back(d);
          sb.push_back(d);
        end
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    arst    = 1'b1;
    cke     = 1'b1;
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    mdl.delete();
    sb.delete();
    last_out = RSTV;
    check("arst_m_valid", W'(m_valid), '0);
    check("arst_m_data", m_data, RSTV);
    check("arst_s_ready", W'(s_ready), W'(1'b1));
    #2;
    arst = 1'b0;
  endtask

  // Monitor: a downstream transfer happens at the next rising edge whenever valid & ready.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL mon_underflow: got word %h, expected no transfer at %0t", m_data, $time);
        end else begin
          check("mon_data", m_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    async_reset();

    // Back-to-back stream with the consumer always ready.
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Stall: two words fill the buffer, a third is refused, then drain.
    step(1'b1, W'('hA), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'('hB), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'('hC), 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Clock enable low freezes everything while a word is held.
    step(1'b1, W'('h5), 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, W'('h77), 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Sync reset in FULL: ignored while cke is low, then drops both words.
    step(1'b1, W'('h11), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'('h22), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'('h33), 1'b1, 1'b0, 1'b1);
    step(1'b1, W'('h44), 1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset while FULL.
    step(1'b1, W'('h55), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'('h66), 1'b0, 1'b1, 1'b0);
    async_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Random traffic with occasional clock-enable gaps and sync resets.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 90, $urandom_range(0, 199) < 2);
    end

    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("drained", W'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
